// File: rtl/vic_nest.sv
// vic_nest: vectored priority interrupt controller with per-channel edge/level mode,
// req/ack handshake and nested in-service register. Optional lost-edge counter: VIC_LOST_CNT_EN.
module vic_nest #(
    parameter int unsigned       N_CH       = 4,
    parameter int unsigned       VEC_W      = 8,
    parameter int unsigned       VEC_STRIDE = 4,
    parameter logic [N_CH-1:0]   EDGE_MASK  = N_CH'(4'b0011)
) (
    input  logic                     g_clk,
    input  logic                     g_clr,
    input  logic [N_CH-1:0]          irq,
    input  logic [N_CH-1:0]          mask,
    input  logic                     ien,
    input  logic [VEC_W-1:0]         vec_base,
    input  logic                     int_ack,
    input  logic                     int_done,
    output logic                     i_pending,
    output logic [VEC_W-1:0]         vector_out,
    output logic [$clog2(N_CH)-1:0]  active_id,
    output logic [N_CH-1:0]          in_service,
    output logic                     ack_err,
    output logic [7:0]               lost_cnt
);

    localparam int unsigned ID_W = $clog2(N_CH);

    typedef enum logic {ST_IDLE, ST_REQ} state_e;

    state_e             state_q, state_d;
    logic               req_q, req_d;
    logic [VEC_W-1:0]   vec_q, vec_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic               ack_err_q, ack_err_d;
    logic [N_CH-1:0]    irq_q;
    logic [N_CH-1:0]    pend_q, pend_d;
    logic [N_CH-1:0]    isr_q, isr_d;

    logic [N_CH-1:0]    rise_c, above_c, elig_c, ack_oh_c, isr_done_c;
    logic [ID_W-1:0]    cand_c;
    logic               cand_found_c;
    logic               ack_take_c;
    logic [VEC_W-1:0]   vec_c;

    // Channels strictly above the lowest in-service bit; all ones when nothing is in service.
    assign rise_c     = irq & ~irq_q & EDGE_MASK;
    assign above_c    = (isr_q & (~isr_q + N_CH'(1))) - N_CH'(1);
    assign elig_c     = pend_q & mask & above_c;
    assign ack_take_c = (state_q == ST_REQ) && int_ack;
    assign ack_oh_c   = ack_take_c ? (N_CH'(1) << id_q) : '0;

    // Lowest-index eligible channel wins.
    always_comb begin
        cand_c       = '0;
        cand_found_c = 1'b0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (elig_c[i] && !cand_found_c) begin
                cand_c       = ID_W'(i);
                cand_found_c = 1'b1;
            end
        end
    end

    assign vec_c = vec_base + VEC_W'(VEC_STRIDE) * VEC_W'(cand_c);

    // Edge bits latch until acked; level bits follow irq one cycle late.
    assign pend_d = (EDGE_MASK & ((pend_q & ~ack_oh_c) | rise_c)) | (~EDGE_MASK & irq);

    // Completion retires the lowest set ISR bit before a same-cycle ack is recorded.
    assign isr_done_c = int_done ? (isr_q & (isr_q - N_CH'(1))) : isr_q;
    assign isr_d      = isr_done_c | ack_oh_c;

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        vec_d     = vec_q;
        id_d      = id_q;
        ack_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ack_err_d = int_ack;
                if (ien && cand_found_c) begin
                    state_d = ST_REQ;
                    req_d   = 1'b1;
                    vec_d   = vec_c;
                    id_d    = cand_c;
                end
            end
            ST_REQ: begin
                if (int_ack || !ien) begin
                    state_d = ST_IDLE;
                    req_d   = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            state_q   <= ST_IDLE;
            req_q     <= 1'b0;
            vec_q     <= '0;
            id_q      <= '0;
            ack_err_q <= 1'b0;
            irq_q     <= '0;
            pend_q    <= '0;
            isr_q     <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            vec_q     <= vec_d;
            id_q      <= id_d;
            ack_err_q <= ack_err_d;
            irq_q     <= irq;
            pend_q    <= pend_d;
            isr_q     <= isr_d;
        end
    end

`ifdef VIC_LOST_CNT_EN
    logic [7:0] lost_q, lost_d;

    // One count per cycle in which any already-pending edge channel sees another edge.
    always_comb begin
        lost_d = lost_q;
        if (|(rise_c & pend_q) && (lost_q != 8'hFF)) begin
            lost_d = lost_q + 8'd1;
        end
    end

    always_ff @(posedge g_clk or negedge g_clr) begin
        if (!g_clr) begin
            lost_q <= 8'h00;
        end else begin
            lost_q <= lost_d;
        end
    end

    assign lost_cnt = lost_q;
`else
    assign lost_cnt = 8'h00;
`endif

    assign i_pending  = req_q;
    assign vector_out = vec_q;
    assign active_id  = id_q;
    assign in_service = isr_q;
    assign ack_err    = ack_err_q;

endmodule

// File: doc/vic_nest.md
Name: vic_nest

Overview:
- Parametrised vectored priority interrupt controller; next-generation successor to the fixed 4-input hardware vector priority interrupt system.
- Adds per-channel edge/level mode, a registered request/acknowledge handshake, and an in-service register supporting nested preemption.
- Sits beside the controller: presents i_pending plus a vector address that feeds the PC mux.
- Channel 0 has the highest priority.

Parameters:
- N_CH, 4, number of interrupt channels (2..16).
- VEC_W, 8, vector/address width.
- VEC_STRIDE, 4, address distance between consecutive channel vectors.
- EDGE_MASK, 4'b0011, per-channel mode; 1 = rising-edge, 0 = level (width N_CH).

Ports:
- g_clk  in  1  clock, all state on rising edge.
- g_clr  in  1  reset; asynchronous, active-low.
- irq  in  N_CH  raw interrupt requests.
- mask  in  N_CH  per-channel enable; 1 = enabled.
- ien  in  1  global interrupt enable.
- vec_base  in  VEC_W  vector table base address.
- int_ack  in  1  controller accepts presented vector (1-cycle pulse).
- int_done  in  1  return-from-interrupt (1-cycle pulse).
- i_pending  out  1  request to controller.
- vector_out  out  VEC_W  vec_base + id*VEC_STRIDE, modulo 2^VEC_W.
- active_id  out  clog2(N_CH)  id of the presented request.
- in_service  out  N_CH  in-service register (ISR).
- ack_err  out  1  1-cycle pulse: int_ack seen while i_pending=0.
- lost_cnt  out  8  lost-edge counter (see Optional Feature).

Behaviour:
- Reset (g_clr=0, async): PEND, ISR, irq_q = 0; i_pending = 0; vector_out = 0; active_id = 0; ack_err = 0; lost_cnt = 0; FSM = IDLE. Reset mid-handshake drops everything; no ack is owed.
- Edge channel: PEND[i] sets when irq[i]=1 and irq_q[i]=0 (irq_q = irq registered). It clears only on ack of channel i.
- Level channel: PEND[i] = irq[i] registered every cycle; ack does not clear it.
- Eligible set = PEND & mask & priority-above-ISR. A channel is above ISR if its index is lower than the lowest set ISR bit; with ISR = 0, all channels are eligible.
- Candidate = lowest-index eligible channel.
- FSM IDLE: if ien=1 and a candidate exists, go to REQ next cycle. On entry, register active_id = candidate, vector_out = computed address, i_pending = 1.
  - Latency: irq edge to i_pending is 2 cycles (1 for PEND, 1 for the request register).
- FSM REQ:
  - vector_out and active_id are frozen; a later higher-priority arrival does not change them.
  - On int_ack: set ISR[active_id]; clear PEND[active_id] if that channel is edge mode; i_pending = 0 next cycle; go to IDLE.
  - If ien=0 and int_ack=0: withdraw; i_pending = 0 next cycle, PEND retained, go to IDLE.
  - A mask change alone does not withdraw the request.
- int_done clears the lowest-index set ISR bit. If ISR = 0, int_done is ignored.
- Same-cycle int_done and int_ack: apply the int_done clear first, then set the acked bit.
- int_ack in IDLE: ignored, and ack_err pulses for 1 cycle.
- Nesting: a channel lower-indexed than the current service preempts; depth is bounded by N_CH. An equal or lower priority channel waits until int_done.
- After any ack or withdrawal, at least 1 IDLE cycle occurs before the next REQ.

Optional Feature:
- Macro VIC_LOST_CNT_EN.
- Defined: lost_cnt increments, saturating at 8'hFF, whenever an edge channel detects a rising edge while its PEND bit is already set. If several channels do so in one cycle, lost_cnt adds 1 only. Cleared by reset.
- Not defined: lost_cnt is tied to 8'h00 and no counter logic is generated.

Test Plan:
- Defaults, vec_base=8'h40, mask=4'hF, ien=1; pulse irq[2] (level channel) -> i_pending=1 two cycles later, vector_out=8'h48, active_id=2. Ack -> in_service=4'b0100, i_pending drops next cycle.
- While serving ch2, pulse irq[0] -> vector_out=8'h40. Ack -> in_service=4'b0101. Then int_done -> in_service=4'b0100.
- Assert irq[3] and irq[1] in the same cycle, ISR=0 -> ch1 presented (8'h44). After ack+done, ch3 presented (8'h4C).
- In REQ for ch3, drop ien without ack -> i_pending=0 next cycle, PEND[3] kept. Restore ien -> ch3 re-presented.
- int_ack with i_pending=0 -> ack_err pulses 1 cycle, ISR unchanged. Pull g_clr low mid-REQ -> all outputs 0 immediately.
- VIC_LOST_CNT_EN defined: 3 rising edges on irq[0] with no ack -> lost_cnt=2. 300 edges -> lost_cnt=8'hFF.
